// File: rtl/serial_pattern_src.sv
// serial_pattern_src
//   Emits a WIDTH-bit pattern MSB first on a serial line, holding each bit
//   for DIV clock cycles. The pattern is captured into a shadow register by
//   `load`. `start` copies the shadow into the active shift register and
//   begins emission.
//
//   Optional feature macro: SERIAL_PATTERN_SRC_REPEAT_EN
//     - defined:   the pattern is reloaded from the shadow register and
//                  repeats without a gap until stop or clr.
//     - undefined: one pattern is emitted per start (default build).
//
// Parameters
//   WIDTH   pattern length in bits (>= 2)
//   DIV     clk cycles each bit is held (>= 1)
// Ports
//   clk      clock; all state changes on its rising edge
//   clr      asynchronous active-high reset
//   load     capture `pattern` into the shadow register
//   pattern  WIDTH-bit sequence to emit, MSB first
//   start    begin emitting the shadow pattern (ignored while busy)
//   stop     abort an emission in progress (wins over start and completion)
//   bit_out  serial data line
//   bit_stb  one-cycle pulse on the first cycle of each new bit
//   busy     high while an emission is in progress
//   done     one-cycle pulse when a full pattern has been emitted
module serial_pattern_src #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic             start,
    input  logic             stop,
    output logic             bit_out,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    // A divider of at least one bit keeps DIV=1 legal; it then stays at 0.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [DW-1:0]    div_reg;
    logic [IW-1:0]    idx_reg;
    logic             loaded_reg;

    // Pattern that a start (or a repeat reload) takes on this edge: a load on
    // the same edge supersedes the shadow contents.
    logic [WIDTH-1:0] src_next;
    assign src_next = load ? pattern : shadow_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            shift_reg  <= '0;
            div_reg    <= '0;
            idx_reg    <= '0;
            loaded_reg <= 1'b0;
            bit_out    <= 1'b0;
            bit_stb    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Shadow capture is independent of the state machine.
            if (load) begin
                shadow_reg <= pattern;
                loaded_reg <= 1'b1;
            end

            done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    bit_out <= 1'b0;
                    bit_stb <= 1'b0;
                    busy    <= 1'b0;
                    if (start && !stop && (loaded_reg || load)) begin
                        state_reg <= SHIFT;
                        shift_reg <= src_next;
                        div_reg   <= '0;
                        idx_reg   <= '0;
                        bit_out   <= src_next[WIDTH-1];
                        bit_stb   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (stop) begin
                        // Abort: no done pulse, even on the final-bit edge.
                        state_reg <= IDLE;
                        div_reg   <= '0;
                        idx_reg   <= '0;
                        bit_out   <= 1'b0;
                        bit_stb   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (div_reg != DIV_LAST) begin
                        div_reg <= div_reg + 1'b1;
                        bit_stb <= 1'b0;
                    end else if (idx_reg != IDX_LAST) begin
                        // Advance to the next bit; the current MSB has been
                        // held for DIV cycles.
                        div_reg   <= '0;
                        idx_reg   <= idx_reg + 1'b1;
                        shift_reg <= shift_reg << 1;
                        bit_out   <= shift_reg[WIDTH-2];
                        bit_stb   <= 1'b1;
                    end else begin
                        // Last bit has been held for DIV cycles.
                        done    <= 1'b1;
                        div_reg <= '0;
                        idx_reg <= '0;
`ifdef SERIAL_PATTERN_SRC_REPEAT_EN
                        // Seamless restart from the shadow register.
                        shift_reg <= src_next;
                        bit_out   <= src_next[WIDTH-1];
                        bit_stb   <= 1'b1;
                        busy      <= 1'b1;
`else
                        state_reg <= IDLE;
                        bit_out   <= 1'b0;
                        bit_stb   <= 1'b0;
                        busy      <= 1'b0;
`endif
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_src.sv
module tb_serial_pattern_src;

    logic        clk = 1'b0;
    logic        clr = 1'b1;

    // DUT 0: WIDTH=16, DIV=4
    logic        load0 = 1'b0, start0 = 1'b0, stop0 = 1'b0;
    logic [15:0] pat0 = '0;
    logic        bo0, bs0, by0, dn0;

    // DUT 1: WIDTH=16, DIV=1
    logic        load1 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
    logic [15:0] pat1 = '0;
    logic        bo1, bs1, by1, dn1;

    int checks = 0;
    int errors = 0;

    serial_pattern_src #(.WIDTH(16), .DIV(4)) u0 (
        .clk(clk), .clr(clr), .load(load0), .pattern(pat0), .start(start0),
        .stop(stop0), .bit_out(bo0), .bit_stb(bs0), .busy(by0), .done(dn0)
    );

    serial_pattern_src #(.WIDTH(16), .DIV(1)) u1 (
        .clk(clk), .clr(clr), .load(load1), .pattern(pat1), .start(start1),
        .stop(stop1), .bit_out(bo1), .bit_stb(bs1), .busy(by1), .done(dn1)
    );

    always #5 clk = ~clk;

    // Compares {bit_out, bit_stb, busy, done}.
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={out,stb,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs i cycles after the start edge, DIV=4, one-shot.
    function automatic logic [3:0] exp4(input logic [15:0] p, input int i);
        logic b;
        b = p[15 - i / 4];
        return {b, (i % 4 == 0), 1'b1, 1'b0};
    endfunction

    // Assumes the start edge has just been sampled; checks the full
    // emission, the done pulse and the return to idle.
    task automatic run0(input logic [15:0] p, input string tag);
        for (int i = 0; i < 64; i++) begin
            chk(tag, {bo0, bs0, by0, dn0}, exp4(p, i));
            step();
        end
        chk({tag, "_done"}, {bo0, bs0, by0, dn0}, 4'b0001);
        step();
        chk({tag, "_idle"}, {bo0, bs0, by0, dn0}, 4'b0000);
    endtask

    initial begin
        int viol;

        // Reset state.
        step();
        chk("reset0", {bo0, bs0, by0, dn0}, 4'b0000);
        chk("reset1", {bo1, bs1, by1, dn1}, 4'b0000);
        clr = 1'b0;
        step();

        // Start without any load is ignored for 100 cycles.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (bo0 !== 1'b0 || by0 !== 1'b0) viol++;
            step();
        end
        checks++;
        assert (viol == 0) else begin
            errors++;
            $error("FAIL start_no_load observed=%0d active cycles expected=0", viol);
        end

        // One-shot F0F0.
        pat0 = 16'hF0F0; load0 = 1'b1;
        step();
        load0 = 1'b0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run0(16'hF0F0, "oneshot_f0f0");

        // Stop mid-emission at cycle 20.
        pat0 = 16'hFFFF; load0 = 1'b1;
        step();
        load0 = 1'b0; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (i == 20) chk("stop_pre", {bo0, bs0, by0, dn0}, exp4(16'hFFFF, i));
            if (i < 20) step();
        end
        stop0 = 1'b1;
        step();
        stop0 = 1'b0;
        chk("stop_edge", {bo0, bs0, by0, dn0}, 4'b0000);
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (dn0 !== 1'b0 || by0 !== 1'b0) viol++;
        end
        checks++;
        assert (viol == 0) else begin
            errors++;
            $error("FAIL stop_no_done observed=%0d cycles expected=0", viol);
        end

        // Start and stop together in IDLE: stop wins.
        start0 = 1'b1; stop0 = 1'b1;
        step();
        start0 = 1'b0; stop0 = 1'b0;
        chk("start_stop_idle", {bo0, bs0, by0, dn0}, 4'b0000);

        // Load during SHIFT only updates the shadow register.
        pat0 = 16'hAAAA; load0 = 1'b1;
        step();
        load0 = 1'b0; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 0) chk("load_in_shift", {bo0, bs0, by0, dn0}, exp4(16'hAAAA, i));
            if (i == 10) begin pat0 = 16'h0001; load0 = 1'b1; end
            step();
            load0 = 1'b0;
        end
        chk("load_in_shift_done", {bo0, bs0, by0, dn0}, 4'b0001);
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run0(16'h0001, "after_reload_0001");

        // Load and start on the same edge use the new pattern.
        pat0 = 16'h8001; load0 = 1'b1; start0 = 1'b1;
        step();
        load0 = 1'b0; start0 = 1'b0;
        run0(16'h8001, "load_start_same");

        // Stop coinciding with the final-bit edge: no done.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("final_pre", {bo0, bs0, by0, dn0}, exp4(16'h8001, 63));
        stop0 = 1'b1;
        step();
        stop0 = 1'b0;
        chk("stop_final_edge", {bo0, bs0, by0, dn0}, 4'b0000);

        // Asynchronous clear mid-emission, then start must be ignored.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("pre_clr", {bo0, bs0, by0, dn0}, exp4(16'h8001, 30));
        #2 clr = 1'b1;
        #1;
        chk("async_clr", {bo0, bs0, by0, dn0}, 4'b0000);
        step();
        clr = 1'b0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        chk("start_after_clr", {bo0, bs0, by0, dn0}, 4'b0000);

        // DIV=1 pattern 000F on the second instance.
        pat1 = 16'h000F; load1 = 1'b1; start1 = 1'b1;
        step();
        load1 = 1'b0; start1 = 1'b0;
`ifdef SERIAL_PATTERN_SRC_REPEAT_EN
        for (int i = 0; i < 48; i++) begin
            chk("repeat_div1", {bo1, bs1, by1, dn1},
                {pat1[15 - (i % 16)], 1'b1, 1'b1, (i > 0 && i % 16 == 0)});
            step();
        end
        stop1 = 1'b1;
        step();
        stop1 = 1'b0;
        chk("repeat_stop", {bo1, bs1, by1, dn1}, 4'b0000);
`else
        for (int i = 0; i < 16; i++) begin
            chk("oneshot_div1", {bo1, bs1, by1, dn1}, {pat1[15 - i], 1'b1, 1'b1, 1'b0});
            step();
        end
        chk("oneshot_div1_done", {bo1, bs1, by1, dn1}, 4'b0001);
        step();
        chk("oneshot_div1_idle", {bo1, bs1, by1, dn1}, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_src.md
SERIAL_PATTERN_SRC -- requirements
Module: serial_pattern_src

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the pattern length in bits (minimum 2).
REQ-002 SHALL have parameter DIV, default 4, the number of clk cycles each bit is held (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 SHALL have port load, input, 1 bit, a request to capture pattern into the shadow register.
REQ-006 SHALL have port pattern, input, WIDTH bits, the bit sequence to emit, MSB first.
REQ-007 SHALL have port start, input, 1 bit, a request to begin shifting out the shadow pattern.
REQ-008 SHALL have port stop, input, 1 bit, which aborts an emission in progress.
REQ-009 SHALL have port bit_out, output, 1 bit, the serial data line that feeds the downstream run detector input.
REQ-010 SHALL have port bit_stb, output, 1 bit, a one-cycle pulse on the first cycle each new bit appears on bit_out.
REQ-011 SHALL have port busy, output, 1 bit, high while an emission is in progress.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse when a full pattern has been emitted.

Function
REQ-013 SHALL implement two states, IDLE and SHIFT; in IDLE, bit_out=0, bit_stb=0 and busy=0.
REQ-014 SHALL, when load=1 on an edge in any state, capture pattern into the shadow register and set the internal flag loaded=1.
REQ-015 SHALL, when start=1 and stop=0 at edge N in IDLE with loaded=1 (or load=1 on the same edge), transition as follows:
- go to SHIFT;
- copy shadow into the shift register, using the new pattern if load=1 on the same edge;
- drive bit_out=pattern MSB, bit_stb=1, busy=1 from edge N.
REQ-016 SHALL ignore start in IDLE when loaded=0 and load=0, and SHALL ignore start while in SHIFT.
REQ-017 SHALL time bits within SHIFT as follows:
- a divider counts 0..DIV-1;
- bit k (k=0 is MSB) is on bit_out for the DIV cycles following edge N+k*DIV;
- bit_stb is high only in the first of those cycles;
- when DIV=1, bit_stb is high on every cycle.
REQ-018 SHALL use a bit index counter of width clog2(WIDTH+1), with no wrap within one pattern.
REQ-019 SHALL, at edge N+WIDTH*DIV, without the repeat feature, return to IDLE with done=1 for exactly one cycle, busy=0 and bit_out=0; busy is therefore high for exactly WIDTH*DIV cycles.
REQ-020 SHALL, on load during SHIFT, update only the shadow register; the active shift register is unaffected until the next start or reload.
REQ-021 SHALL, on stop=1 in SHIFT, go to IDLE on that edge with busy=0, bit_out=0, bit_stb=0 and no done pulse.
REQ-022 SHALL, when stop=1 and start=1 on the same edge, give stop priority, so start is ignored.
REQ-023 SHALL, when stop=1 and the final-bit edge coincide, give stop priority, so no done pulse is issued.
REQ-024 SHALL keep done and bit_stb mutually consistent: both may be high together only in repeat mode.

Reset
REQ-025 SHALL, while clr=1, immediately force state=IDLE, bit_out=0, bit_stb=0, busy=0, done=0, loaded=0, and clear the shadow register, shift register, divider and bit index to 0.
REQ-026 SHALL, when clr is asserted mid-emission, abort the emission without a done pulse; a new load is required before start is accepted.

Configuration
REQ-027 SHALL support the macro SERIAL_PATTERN_SRC_REPEAT_EN.
REQ-028 SHALL, when SERIAL_PATTERN_SRC_REPEAT_EN is defined, behave as follows at edge N+WIDTH*DIV:
- reload the shift register from the shadow register and continue with the new MSB, with no gap cycle;
- assert bit_stb=1 and done=1 in that cycle;
- keep busy=1;
- repeat the pattern indefinitely until stop or clr.
REQ-029 SHALL, when SERIAL_PATTERN_SRC_REPEAT_EN is undefined, emit one pattern per start, as in REQ-019.

Verification
REQ-030 SHALL cover the one-shot case: WIDTH=16, DIV=4, load 16'hF0F0, then start -> bit_out is 1 for 16 cycles, 0 for 16, 1 for 16, 0 for 16; 16 bit_stb pulses; busy high for 64 cycles; one done pulse at cycle 64.
REQ-031 SHALL cover start without load: pulse start after reset -> busy stays 0 and bit_out stays 0 for 100 cycles.
REQ-032 SHALL cover stop mid-emission: pattern 16'hFFFF, stop at cycle 20 -> busy and bit_out drop on the next edge; no done pulse.
REQ-033 SHALL cover load during SHIFT: emit 16'hAAAA, load 16'h0001 at cycle 10 -> the remaining bits are still from 16'hAAAA; the next start emits 15 zeros followed by a 1.
REQ-034 SHALL cover reset mid-operation: assert clr asynchronously between edges at cycle 30 -> all outputs are 0 before the next edge; start after clr is ignored.
REQ-035 SHALL cover repeat mode: with REPEAT_EN defined, pattern 16'h000F and DIV=1 -> the bit_out period is 16 cycles, done pulses every 16 cycles, busy stays high until stop.
